// File: rtl/card_reveal_sequencer_pkg.sv
// Shared poker definitions: sequencer states, hand geometry and card helpers.
package card_reveal_sequencer_pkg;

  localparam int NUM_CARDS = 9;
  localparam int RANK_W    = 4;
  localparam int SUIT_W    = 2;
  localparam int LEVEL_W   = 3;
  localparam int IDX_W     = 4;
  localparam int RANK_MIN  = 1;
  localparam int RANK_MAX  = 13;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DEAL   = 2'd1,
    ST_RESULT = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Rank of the card at 0-based position pos inside a packed hand.
  function automatic logic [RANK_W-1:0] pick_rank(
    input logic [NUM_CARDS*RANK_W-1:0] nums,
    input logic [IDX_W-1:0]            pos
  );
    logic [RANK_W-1:0] r;
    r = {RANK_W{1'b0}};
    for (int i = 0; i < NUM_CARDS; i++) begin
      if (pos == IDX_W'(i)) begin
        r = nums[i*RANK_W +: RANK_W];
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Suit of the card at 0-based position pos inside a packed hand.
  function automatic logic [SUIT_W-1:0] pick_suit(
    input logic [NUM_CARDS*SUIT_W-1:0] suits,
    input logic [IDX_W-1:0]            pos
  );
    logic [SUIT_W-1:0] s;
    s = {SUIT_W{1'b0}};
    for (int i = 0; i < NUM_CARDS; i++) begin
      if (pos == IDX_W'(i)) begin
        s = suits[i*SUIT_W +: SUIT_W];
      end else begin
        s = s;
      end
    end
    return s;
  endfunction

  // A rank is playable only inside 1..13; 0, 14 and 15 are corrupt encodings.
  function automatic logic rank_ok(input logic [RANK_W-1:0] r);
    return (r >= RANK_W'(RANK_MIN)) && (r <= RANK_W'(RANK_MAX));
  endfunction

endpackage

// File: rtl/card_reveal_sequencer.sv
// Reveals a latched nine-card hand one card at a time, paced by a slow tick
// strobe, then shows the winner and the winner's hand level until reloaded.
module card_reveal_sequencer
  import card_reveal_sequencer_pkg::*;
#(
  parameter int TICKS_PER_CARD = 2,
  parameter int RESULT_TICKS   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load,
  input  logic [NUM_CARDS*RANK_W-1:0]   cards_number,
  input  logic [NUM_CARDS*SUIT_W-1:0]   cards_flower,
  input  logic                          winner_in,
  input  logic [LEVEL_W-1:0]            card_level_p1,
  input  logic [LEVEL_W-1:0]            card_level_p2,
  input  logic                          tick,
  output logic                          busy,
  output logic                          disp_valid,
  output logic [IDX_W-1:0]              disp_idx,
  output logic [RANK_W-1:0]             disp_number,
  output logic [SUIT_W-1:0]             disp_flower,
  output logic [NUM_CARDS-1:0]          revealed_mask,
  output logic                          result_valid,
  output logic                          winner_out,
  output logic [LEVEL_W-1:0]            level_out,
  output logic                          done,
  output logic                          card_err
);

  // Terminal counts: the counter compares against N-1 because the Nth tick
  // itself causes the advance.
  localparam logic [3:0] CARD_LAST = 4'(TICKS_PER_CARD - 1);
  localparam logic [3:0] RES_LAST  = 4'(RESULT_TICKS - 1);

  state_e                        state_q, state_d;
  logic [3:0]                    cnt_q, cnt_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [NUM_CARDS*RANK_W-1:0]   nums_q, nums_d;
  logic [NUM_CARDS*SUIT_W-1:0]   suits_q, suits_d;
  logic                          win_q, win_d;
  logic [LEVEL_W-1:0]            lvl1_q, lvl1_d;
  logic [LEVEL_W-1:0]            lvl2_q, lvl2_d;
  logic                          busy_q, busy_d;
  logic                          dv_q, dv_d;
  logic [RANK_W-1:0]             num_q, num_d;
  logic [SUIT_W-1:0]             fl_q, fl_d;
  logic [NUM_CARDS-1:0]          mask_q, mask_d;
  logic                          rv_q, rv_d;
  logic                          wout_q, wout_d;
  logic [LEVEL_W-1:0]            lout_q, lout_d;
  logic                          done_q, done_d;
  logic                          err_q, err_d;
  logic [RANK_W-1:0]             rank_s;

  // Next-state and next-output logic for the reveal sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    nums_d  = nums_q;
    suits_d = suits_q;
    win_d   = win_q;
    lvl1_d  = lvl1_q;
    lvl2_d  = lvl2_q;
    dv_d    = dv_q;
    num_d   = num_q;
    fl_d    = fl_q;
    mask_d  = mask_q;
    rv_d    = rv_q;
    wout_d  = wout_q;
    lout_d  = lout_q;
    err_d   = err_q;
    rank_s  = {RANK_W{1'b0}};
    case (state_q)
      ST_IDLE, ST_DONE: begin
        // A tick coinciding with the load is dropped: the counter starts at 0.
        if (load) begin
          rank_s  = pick_rank(cards_number, 4'd0);
          state_d = ST_DEAL;
          cnt_d   = 4'd0;
          idx_d   = 4'd1;
          nums_d  = cards_number;
          suits_d = cards_flower;
          win_d   = winner_in;
          lvl1_d  = card_level_p1;
          lvl2_d  = card_level_p2;
          dv_d    = 1'b1;
          num_d   = rank_ok(rank_s) ? rank_s : {RANK_W{1'b0}};
          fl_d    = pick_suit(cards_flower, 4'd0);
          mask_d  = {{(NUM_CARDS-1){1'b0}}, 1'b1};
          rv_d    = 1'b0;
          wout_d  = 1'b0;
          lout_d  = {LEVEL_W{1'b0}};
          err_d   = ~rank_ok(rank_s);
        end else begin
          state_d = state_q;
        end
      end
      ST_DEAL: begin
        if (tick) begin
          if (cnt_q == CARD_LAST) begin
            cnt_d = 4'd0;
            if (idx_q == IDX_W'(NUM_CARDS)) begin
              state_d = ST_RESULT;
              dv_d    = 1'b0;
              num_d   = {RANK_W{1'b0}};
              fl_d    = {SUIT_W{1'b0}};
              rv_d    = 1'b1;
              wout_d  = win_q;
              lout_d  = win_q ? lvl2_q : lvl1_q;
            end else begin
              // idx_q is the 1-based index of the shown card, i.e. the
              // 0-based position of the next one.
              rank_s = pick_rank(nums_q, idx_q);
              idx_d  = idx_q + 4'd1;
              num_d  = rank_ok(rank_s) ? rank_s : {RANK_W{1'b0}};
              fl_d   = pick_suit(suits_q, idx_q);
              mask_d = mask_q | ({{(NUM_CARDS-1){1'b0}}, 1'b1} << idx_q);
              err_d  = err_q | ~rank_ok(rank_s);
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_RESULT: begin
        if (tick) begin
          if (cnt_q == RES_LAST) begin
            cnt_d   = 4'd0;
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
    busy_d = (state_d == ST_DEAL) || (state_d == ST_RESULT);
    done_d = (state_d == ST_DONE);
  end

  // State, latched hand and every output register; reset clears all of them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= {IDX_W{1'b0}};
      nums_q  <= {(NUM_CARDS*RANK_W){1'b0}};
      suits_q <= {(NUM_CARDS*SUIT_W){1'b0}};
      win_q   <= 1'b0;
      lvl1_q  <= {LEVEL_W{1'b0}};
      lvl2_q  <= {LEVEL_W{1'b0}};
      busy_q  <= 1'b0;
      dv_q    <= 1'b0;
      num_q   <= {RANK_W{1'b0}};
      fl_q    <= {SUIT_W{1'b0}};
      mask_q  <= {NUM_CARDS{1'b0}};
      rv_q    <= 1'b0;
      wout_q  <= 1'b0;
      lout_q  <= {LEVEL_W{1'b0}};
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      nums_q  <= nums_d;
      suits_q <= suits_d;
      win_q   <= win_d;
      lvl1_q  <= lvl1_d;
      lvl2_q  <= lvl2_d;
      busy_q  <= busy_d;
      dv_q    <= dv_d;
      num_q   <= num_d;
      fl_q    <= fl_d;
      mask_q  <= mask_d;
      rv_q    <= rv_d;
      wout_q  <= wout_d;
      lout_q  <= lout_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign busy          = busy_q;
  assign disp_valid    = dv_q;
  assign disp_idx      = idx_q;
  assign disp_number   = num_q;
  assign disp_flower   = fl_q;
  assign revealed_mask = mask_q;
  assign result_valid  = rv_q;
  assign winner_out    = wout_q;
  assign level_out     = lout_q;
  assign done          = done_q;
  assign card_err      = err_q;

endmodule
